// File: rtl/tile_seq_pkg.sv
// Shared definitions for the tile/layer sequencer: FSM encoding and the
// derived-constant helpers used to size address strides.
package tile_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_REQ = 3'd2,
    ST_INCR     = 3'd3,
    ST_READY    = 3'd4
  } state_e;

  // Elements packed in one BRAM word
  function automatic int unsigned f_wpb(input int unsigned bram_w, input int unsigned data_w);
    return bram_w / data_w;
  endfunction

  // Weight BRAM words spanned by one tile
  function automatic int unsigned f_stride(input int unsigned n, input int unsigned macs,
                                           input int unsigned bram_w, input int unsigned data_w);
    return macs * (n / f_wpb(bram_w, data_w));
  endfunction

  function automatic int unsigned f_num_tiles(input int unsigned n, input int unsigned macs);
    return n / macs;
  endfunction

  // Weight BRAM words spanned by one layer
  function automatic int unsigned f_w_layer_off(input int unsigned n, input int unsigned macs,
                                                input int unsigned bram_w, input int unsigned data_w);
    return f_num_tiles(n, macs) * f_stride(n, macs, bram_w, data_w);
  endfunction

  // Input BRAM words per layer vector, rounded up
  function automatic int unsigned f_i_layer_off(input int unsigned n, input int unsigned bram_w,
                                                input int unsigned data_w);
    return (n + f_wpb(bram_w, data_w) - 1) / f_wpb(bram_w, data_w);
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Tile/layer counters and incrementally updated BRAM base addresses.
// Ports: i_clear (abort, zero everything), i_init (start, latch layer count),
// i_step_tile / i_step_layer (advance), address/select outputs and last flags.
module tile_addr_gen
  import tile_seq_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned MACS_PER_ROW = 2,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned BRAM_W       = 64,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned MAX_LAYERS   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_clear,
  input  logic                             i_init,
  input  logic [$clog2(MAX_LAYERS+1)-1:0]  i_num_layers,
  input  logic                             i_step_tile,
  input  logic                             i_step_layer,
  output logic [$clog2(MEM_DEPTH)-1:0]     o_weight_base_addr,
  output logic [$clog2(MEM_DEPTH)-1:0]     o_input_base_addr,
  output logic [$clog2(N)-1:0]             o_acc_sel_tile,
  output logic [$clog2(MAX_LAYERS)-1:0]    o_layer_sel,
  output logic                             o_last_tile_in_layer,
  output logic                             o_last_layer
);

  localparam int unsigned AW          = $clog2(MEM_DEPTH);
  localparam int unsigned LW          = $clog2(MAX_LAYERS);
  localparam int unsigned CW          = $clog2(MAX_LAYERS + 1);
  localparam int unsigned SW          = $clog2(N);
  localparam int unsigned STRIDE      = f_stride(N, MACS_PER_ROW, BRAM_W, DATA_W);
  localparam int unsigned NUM_TILES   = f_num_tiles(N, MACS_PER_ROW);
  localparam int unsigned W_LAYER_OFF = f_w_layer_off(N, MACS_PER_ROW, BRAM_W, DATA_W);
  localparam int unsigned I_LAYER_OFF = f_i_layer_off(N, BRAM_W, DATA_W);

  logic [SW-1:0] r_tile_cnt;
  logic [LW-1:0] r_layer_cnt;
  logic [CW-1:0] r_num_layers;
  logic [AW-1:0] r_weight;
  logic [AW-1:0] r_w_layer_base;
  logic [AW-1:0] r_input;
  logic [AW-1:0] w_next_layer_base;

  // Next layer's weight base; running sum instead of layer_cnt*W_LAYER_OFF
  assign w_next_layer_base = r_w_layer_base + AW'(W_LAYER_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tile_cnt     <= '0;
      r_layer_cnt    <= '0;
      r_num_layers   <= '0;
      r_weight       <= '0;
      r_w_layer_base <= '0;
      r_input        <= '0;
    end else if (i_clear || i_init) begin
      r_tile_cnt     <= '0;
      r_layer_cnt    <= '0;
      r_num_layers   <= i_clear ? '0 : i_num_layers;
      r_weight       <= '0;
      r_w_layer_base <= '0;
      r_input        <= '0;
    end else if (i_step_layer) begin
      r_tile_cnt     <= '0;
      r_layer_cnt    <= r_layer_cnt + LW'(1);
      r_w_layer_base <= w_next_layer_base;
      r_weight       <= w_next_layer_base;
      r_input        <= r_input + AW'(I_LAYER_OFF);
    end else if (i_step_tile) begin
      r_tile_cnt     <= r_tile_cnt + SW'(1);
      r_weight       <= r_weight + AW'(STRIDE);
    end
  end

  assign o_weight_base_addr   = r_weight;
  assign o_input_base_addr    = r_input;
  assign o_acc_sel_tile       = r_tile_cnt;
  assign o_layer_sel          = r_layer_cnt;
  assign o_last_tile_in_layer = (r_tile_cnt == SW'(NUM_TILES - 1));
  assign o_last_layer         = (CW'(r_layer_cnt) == (r_num_layers - CW'(1)));

endmodule

// File: rtl/tile_seq_ctrl.sv
// Tile/layer sequencer: walks 1..MAX_LAYERS layers of NUM_TILES tiles,
// handshaking each tile with the top controller.
// Ports: i_start/i_cfg_num_layers begin a sequence, i_next_tile advances,
// i_abort cancels; o_next_tile_ready, o_busy, address/select outputs,
// o_last_tile (combinational), o_layer_done/o_seq_done/o_cfg_err pulses.
module tile_seq_ctrl
  import tile_seq_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned MACS_PER_ROW = 2,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned BRAM_W       = 64,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned MAX_LAYERS   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic [$clog2(MAX_LAYERS+1)-1:0]  i_cfg_num_layers,
  input  logic                             i_next_tile,
  input  logic                             i_abort,
  output logic                             o_next_tile_ready,
  output logic                             o_busy,
  output logic [$clog2(MEM_DEPTH)-1:0]     o_weight_base_addr,
  output logic [$clog2(MEM_DEPTH)-1:0]     o_input_base_addr,
  output logic [$clog2(N)-1:0]             o_acc_sel_tile,
  output logic [$clog2(MAX_LAYERS)-1:0]    o_layer_sel,
  output logic                             o_last_tile,
  output logic                             o_layer_done,
  output logic                             o_seq_done,
  output logic                             o_cfg_err
);

  localparam int unsigned CW = $clog2(MAX_LAYERS + 1);

  state_e r_state;
  state_e w_next_state;
  logic   w_cfg_ok;
  logic   w_init;
  logic   w_step_tile;
  logic   w_step_layer;
  logic   w_last_tile_in_layer;
  logic   w_last_layer;
  logic   w_accept_req;
  logic   w_cfg_err_d;

  assign w_cfg_ok     = (i_cfg_num_layers >= CW'(1)) && (i_cfg_num_layers <= CW'(MAX_LAYERS));
  assign w_accept_req = (r_state == ST_WAIT_REQ) && i_next_tile && !i_abort;
  assign w_cfg_err_d  = (r_state == ST_IDLE) && i_start && !w_cfg_ok && !i_abort;

  // Next-state and counter-control decode; abort overrides everything
  always_comb begin
    w_next_state = r_state;
    w_init       = 1'b0;
    w_step_tile  = 1'b0;
    w_step_layer = 1'b0;
    if (i_abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && w_cfg_ok) begin
            w_next_state = ST_LOAD;
            w_init       = 1'b1;
          end
        end
        ST_LOAD:     w_next_state = ST_READY;
        ST_READY:    w_next_state = ST_WAIT_REQ;
        ST_WAIT_REQ: if (i_next_tile) w_next_state = ST_INCR;
        ST_INCR: begin
          if (!w_last_tile_in_layer) begin
            w_step_tile  = 1'b1;
            w_next_state = ST_READY;
          end else if (!w_last_layer) begin
            w_step_layer = 1'b1;
            w_next_state = ST_READY;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Done pulses are registered on request acceptance so they show during INCR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      o_busy            <= 1'b0;
      o_next_tile_ready <= 1'b0;
      o_layer_done      <= 1'b0;
      o_seq_done        <= 1'b0;
      o_cfg_err         <= 1'b0;
    end else begin
      r_state           <= w_next_state;
      o_busy            <= (w_next_state != ST_IDLE);
      o_next_tile_ready <= (w_next_state == ST_READY);
      o_layer_done      <= w_accept_req && w_last_tile_in_layer;
      o_seq_done        <= w_accept_req && w_last_tile_in_layer && w_last_layer;
      o_cfg_err         <= w_cfg_err_d;
    end
  end

  tile_addr_gen #(
    .N            (N),
    .MACS_PER_ROW (MACS_PER_ROW),
    .DATA_W       (DATA_W),
    .BRAM_W       (BRAM_W),
    .MEM_DEPTH    (MEM_DEPTH),
    .MAX_LAYERS   (MAX_LAYERS)
  ) u_addr_gen (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_clear              (i_abort),
    .i_init               (w_init),
    .i_num_layers         (i_cfg_num_layers),
    .i_step_tile          (w_step_tile),
    .i_step_layer         (w_step_layer),
    .o_weight_base_addr   (o_weight_base_addr),
    .o_input_base_addr    (o_input_base_addr),
    .o_acc_sel_tile       (o_acc_sel_tile),
    .o_layer_sel          (o_layer_sel),
    .o_last_tile_in_layer (w_last_tile_in_layer),
    .o_last_layer         (w_last_layer)
  );

  // Only meaningful while a sequence is running
  assign o_last_tile = o_busy && w_last_tile_in_layer && w_last_layer;

endmodule
